// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: combinational enables and bubble selects, registered state.
// Defining HAZARD_PERF_CNT_EN adds the saturating stall_cycles/flush_count counters; otherwise both read 0.
module pipeline_hazard_ctrl #(
   parameter int LOAD_BUBBLES = 1
) (
   input  logic        Clk,
   input  logic        Clrn,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rd,
   input  logic        ex_branch_taken,
   input  logic        mem_req,
   input  logic        mem_ready,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_en,
   output logic        exmem_en,
   output logic        memwb_en,
   output logic        ifid_bubble,
   output logic        idex_bubble,
   output logic        memwb_bubble,
   output logic [31:0] stall_cycles,
   output logic [15:0] flush_count
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic [1:0] bcnt, bcnt_nxt;
   logic       load_use;
   logic       mem_wait;

   assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
   assign mem_wait = mem_req && !mem_ready;

   always_comb begin
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      idex_en      = 1'b1;
      exmem_en     = 1'b1;
      memwb_en     = 1'b1;
      ifid_bubble  = 1'b0;
      idex_bubble  = 1'b0;
      memwb_bubble = 1'b0;
      state_nxt    = state;
      bcnt_nxt     = bcnt;
      case (state)
         RUN: begin
            if (mem_wait) begin
               pc_en        = 1'b0;
               ifid_en      = 1'b0;
               idex_en      = 1'b0;
               exmem_en     = 1'b0;
               memwb_bubble = 1'b1;
               state_nxt    = MEM_WAIT;
            end else if (load_use) begin
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_bubble = 1'b1;
               if (LOAD_BUBBLES > 1) begin
                  state_nxt = LOAD_STALL;
                  bcnt_nxt  = 2'(LOAD_BUBBLES - 1);
               end
            end else if (ex_branch_taken) begin
               ifid_bubble = 1'b1;
               idex_bubble = 1'b1;
            end
         end
         LOAD_STALL: begin
            // A memory wait freezes everything, so the remaining bubble count is held.
            if (mem_wait) begin
               pc_en        = 1'b0;
               ifid_en      = 1'b0;
               idex_en      = 1'b0;
               exmem_en     = 1'b0;
               memwb_bubble = 1'b1;
            end else begin
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_bubble = 1'b1;
               bcnt_nxt    = bcnt - 2'd1;
               if (bcnt_nxt == 2'd0) state_nxt = RUN;
            end
         end
         MEM_WAIT: begin
            if (!mem_ready) begin
               pc_en        = 1'b0;
               ifid_en      = 1'b0;
               idex_en      = 1'b0;
               exmem_en     = 1'b0;
               memwb_bubble = 1'b1;
            end else begin
               // Release cycle: a branch held through the freeze squashes now, once.
               state_nxt = RUN;
               if (ex_branch_taken) begin
                  ifid_bubble = 1'b1;
                  idex_bubble = 1'b1;
               end
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         state <= RUN;
         bcnt  <= 2'd0;
      end else begin
         state <= state_nxt;
         bcnt  <= bcnt_nxt;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // ifid_bubble is asserted exactly on the cycles a taken branch squashes.
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (!pc_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
         if (ifid_bubble && (flush_count != '1)) flush_count <= flush_count + 16'd1;
      end
   end
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl with LOAD_BUBBLES=2: reset-held decode table plus multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rt;
      logic       mrd;
      logic [4:0] rd;
      logic       br;
      logic       mreq;
      logic       mrdy;
   } stim_t;

   // {pc, ifid, idex, exmem, memwb, ifid_bub, idex_bub, memwb_bub}
   typedef logic [7:0] exp_t;

   typedef struct {
      stim_t s;
      exp_t  e;
      string nm;
   } vec_t;

   typedef struct {
      exp_t  e;
      string nm;
   } sb_t;

   localparam exp_t E_RUN    = 8'hF8;
   localparam exp_t E_LOAD   = 8'h3A;
   localparam exp_t E_BRANCH = 8'hFE;
   localparam exp_t E_FREEZE = 8'h09;

   logic        Clk, Clrn;
   logic [4:0]  id_rs, id_rt, ex_rd;
   logic        id_uses_rt, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
   logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic        ifid_bubble, idex_bubble, memwb_bubble;
   logic [31:0] stall_cycles;
   logic [15:0] flush_count;

   int n_cmp = 0;
   int n_bad = 0;
   sb_t  sb_q[$];
   vec_t tbl[12];

   pipeline_hazard_ctrl #(.LOAD_BUBBLES(2)) dut (
      .Clk(Clk), .Clrn(Clrn),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
      .ifid_bubble(ifid_bubble), .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                                input logic mrd, input logic [4:0] rd, input logic br,
                                input logic mreq, input logic mrdy);
      stim_t s;
      s.rs = rs; s.rt = rt; s.uses_rt = uses; s.mrd = mrd; s.rd = rd;
      s.br = br; s.mreq = mreq; s.mrdy = mrdy;
      return s;
   endfunction

   function automatic int exp_cnt(input int v);
`ifdef HAZARD_PERF_CNT_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   task automatic drive(input stim_t s);
      id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.uses_rt;
      ex_mem_read = s.mrd; ex_rd = s.rd; ex_branch_taken = s.br;
      mem_req = s.mreq; mem_ready = s.mrdy;
   endtask

   task automatic check_out();
      sb_t  x;
      exp_t act;
      if (sb_q.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL scoreboard: empty queue at %0t", $time);
         return;
      end
      x = sb_q.pop_front();
      act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_bubble, idex_bubble, memwb_bubble};
      n_cmp++;
      if (act !== x.e) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", x.nm, act, x.e, $time);
      end
   endtask

   task automatic chk_cnt(input string nm, input int st, input int fl);
      n_cmp++;
      if (stall_cycles !== 32'(exp_cnt(st))) begin
         n_bad++;
         $display("FAIL %s stall_cycles: got %0d expected %0d", nm, stall_cycles, exp_cnt(st));
      end
      n_cmp++;
      if (flush_count !== 16'(exp_cnt(fl))) begin
         n_bad++;
         $display("FAIL %s flush_count: got %0d expected %0d", nm, flush_count, exp_cnt(fl));
      end
   endtask

   // One cycle: drive at the falling edge, compare the combinational outputs 1 ns later.
   task automatic step(input stim_t s, input exp_t e, input string nm);
      @(negedge Clk);
      drive(s);
      sb_q.push_back('{e: e, nm: nm});
      #1;
      check_out();
   endtask

   task automatic reset_pulse();
      @(negedge Clk);
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
      Clrn = 1'b0;
      #2;
      Clrn = 1'b1;
   endtask

   stim_t idle, lu;

   initial begin
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
      lu   = mk(5, 0, 0, 1, 5, 0, 0, 0);

      tbl[0]  = '{s: idle,                            e: E_RUN,    nm: "tbl idle"};
      tbl[1]  = '{s: lu,                              e: E_LOAD,   nm: "tbl load_use rs"};
      tbl[2]  = '{s: mk(0, 0, 0, 1, 0, 0, 0, 0),      e: E_RUN,    nm: "tbl rd zero"};
      tbl[3]  = '{s: mk(1, 7, 1, 1, 7, 0, 0, 0),      e: E_LOAD,   nm: "tbl load_use rt"};
      tbl[4]  = '{s: mk(1, 7, 0, 1, 7, 0, 0, 0),      e: E_RUN,    nm: "tbl rt unused"};
      tbl[5]  = '{s: mk(5, 0, 0, 0, 5, 0, 0, 0),      e: E_RUN,    nm: "tbl not load"};
      tbl[6]  = '{s: mk(0, 0, 0, 0, 0, 1, 0, 0),      e: E_BRANCH, nm: "tbl branch"};
      tbl[7]  = '{s: mk(5, 0, 0, 1, 5, 1, 0, 0),      e: E_LOAD,   nm: "tbl load over branch"};
      tbl[8]  = '{s: mk(0, 0, 0, 0, 0, 0, 1, 0),      e: E_FREEZE, nm: "tbl mem_wait"};
      tbl[9]  = '{s: mk(0, 0, 0, 0, 0, 0, 1, 1),      e: E_RUN,    nm: "tbl mem ready"};
      tbl[10] = '{s: mk(5, 0, 0, 1, 5, 1, 1, 0),      e: E_FREEZE, nm: "tbl mem over all"};
      tbl[11] = '{s: mk(0, 0, 0, 0, 0, 1, 1, 1),      e: E_BRANCH, nm: "tbl ready+branch"};

      // Reset held low: outputs must be the RUN decode of the current inputs.
      Clrn = 1'b0;
      drive(idle);
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].s, tbl[i].e, tbl[i].nm);
         chk_cnt(tbl[i].nm, 0, 0);
      end
      @(negedge Clk);
      drive(idle);
      #2 Clrn = 1'b1;

      // Load-use with two bubbles
      step(lu,   E_LOAD, "lu cyc0");
      step(idle, E_LOAD, "lu cyc1");
      step(idle, E_RUN,  "lu cyc2");
      step(idle, E_RUN,  "lu cyc3");
      chk_cnt("lu", 2, 0);

      // Register 0 never hazards
      reset_pulse();
      step(mk(0, 0, 0, 1, 0, 0, 0, 0), E_RUN, "r0 cyc0");
      step(idle, E_RUN, "r0 cyc1");
      chk_cnt("r0", 0, 0);

      // Taken branch
      reset_pulse();
      step(mk(0, 0, 0, 0, 0, 1, 0, 0), E_BRANCH, "br cyc0");
      step(idle, E_RUN, "br cyc1");
      chk_cnt("br", 0, 1);

      // Three-cycle memory wait
      reset_pulse();
      for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 0, 0, 0, 1, 0), E_FREEZE, "mw frozen");
      step(mk(0, 0, 0, 0, 0, 0, 1, 1), E_RUN, "mw release");
      step(idle, E_RUN, "mw after");
      chk_cnt("mw", 3, 0);

      // Branch held through a two-cycle wait flushes once on release
      reset_pulse();
      step(mk(0, 0, 0, 0, 0, 1, 1, 0), E_FREEZE, "bw frozen0");
      step(mk(0, 0, 0, 0, 0, 1, 1, 0), E_FREEZE, "bw frozen1");
      step(mk(0, 0, 0, 0, 0, 1, 1, 1), E_BRANCH, "bw release");
      step(idle, E_RUN, "bw after");
      chk_cnt("bw", 2, 1);

      // Memory wait interrupting LOAD_STALL holds the remaining bubble
      reset_pulse();
      step(lu, E_LOAD, "lsw cyc0");
      step(mk(0, 0, 0, 0, 0, 0, 1, 0), E_FREEZE, "lsw frozen");
      step(mk(0, 0, 0, 0, 0, 0, 1, 1), E_LOAD, "lsw resume");
      step(idle, E_RUN, "lsw done");
      chk_cnt("lsw", 3, 0);

      // Reset asserted mid-LOAD_STALL (bcnt=1)
      reset_pulse();
      step(lu, E_LOAD, "rst cyc0");
      chk_cnt("rst before", 0, 0);
      @(negedge Clk);
      chk_cnt("rst pre-pulse", 1, 0);
      drive(idle);
      Clrn = 1'b0;
      sb_q.push_back('{e: E_RUN, nm: "rst immediate"});
      #1;
      check_out();
      chk_cnt("rst immediate", 0, 0);
      #1 Clrn = 1'b1;
      step(idle, E_RUN, "rst after");
      chk_cnt("rst after", 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
